// File: rtl/axis_uart_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_uart_arbiter
// Purpose  : Round-robin, packet-atomic N:1 AXI-Stream arbiter feeding a UART TX
//            FIFO. Optional header beat (0xA0 + grant_id) when UART_ARB_HDR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axis_uart_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC*WIDTH-1:0]   s_axis_data,
  input  logic [NUM_SRC-1:0]         s_axis_valid,
  input  logic [NUM_SRC-1:0]         s_axis_last,
  output logic [NUM_SRC-1:0]         s_axis_ready,
  output logic [WIDTH-1:0]           m_axis_data,
  output logic                       m_axis_valid,
  output logic                       m_axis_last,
  input  logic                       m_axis_ready,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic [15:0]                pkt_count
);

  localparam int GW = $clog2(NUM_SRC);

`ifdef UART_ARB_HDR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, XFER = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd2} state_t;
`endif

  state_t          state, state_nxt;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   winner;
  logic            any_valid;
  logic            last_fire;
  logic [WIDTH-1:0] sel_data;
`ifdef UART_ARB_HDR_EN
  logic [7:0]      hdr_byte;
`endif

  assign any_valid = |s_axis_valid;
  assign busy      = (state != IDLE);
  assign last_fire = (state == XFER) && m_axis_valid && m_axis_ready && m_axis_last;

  // Round-robin search starting one past the previous winner, with wrap.
  always_comb begin
    logic          found;
    logic [GW-1:0] idx;
    found  = 1'b0;
    idx    = '0;
    winner = last_grant;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = GW'((int'(last_grant) + k) % NUM_SRC);
      if (!found && s_axis_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (GW'(i) == grant_id) sel_data = s_axis_data[i*WIDTH +: WIDTH];
    end
  end

`ifdef UART_ARB_HDR_EN
  assign hdr_byte = 8'hA0 + 8'(grant_id);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    m_axis_data  = '0;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    s_axis_ready = '0;
    case (state)
      IDLE: begin
`ifdef UART_ARB_HDR_EN
        if (any_valid) state_nxt = HDR;
`else
        if (any_valid) state_nxt = XFER;
`endif
      end
`ifdef UART_ARB_HDR_EN
      HDR: begin
        m_axis_data  = WIDTH'(hdr_byte);
        m_axis_valid = 1'b1;
        if (m_axis_ready) state_nxt = XFER;
      end
`endif
      XFER: begin
        m_axis_data            = sel_data;
        m_axis_valid           = s_axis_valid[grant_id];
        m_axis_last            = s_axis_last[grant_id];
        s_axis_ready[grant_id] = m_axis_ready;
        if (last_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last_grant resets to NUM_SRC-1 so source 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_id   <= '0;
      last_grant <= GW'(NUM_SRC - 1);
      pkt_count  <= '0;
    end else begin
      if (state == IDLE && any_valid) grant_id <= winner;
      if (last_fire) begin
        last_grant <= grant_id;
        pkt_count  <= pkt_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/axis_uart_arbiter.md
AXIS_UART_ARBITER -- requirements
Module: axis_uart_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data byte width.
REQ-002 SHALL have parameter NUM_SRC, default 4, number of AXIS requesters; legal range 2..8.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_axis_data  input  NUM_SRC*WIDTH  source data; source i occupies bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port s_axis_valid  input  NUM_SRC  per-source valid.
REQ-007 SHALL have port s_axis_last  input  NUM_SRC  per-source end-of-packet.
REQ-008 SHALL have port s_axis_ready  output  NUM_SRC  per-source ready.
REQ-009 SHALL have port m_axis_data  output  WIDTH  data to the FIFO/UART TX sink.
REQ-010 SHALL have port m_axis_valid  output  1  sink valid.
REQ-011 SHALL have port m_axis_last  output  1  sink end-of-packet.
REQ-012 SHALL have port m_axis_ready  input  1  sink ready.
REQ-013 SHALL have port grant_id  output  clog2(NUM_SRC)  index of the granted source; holds its last value when idle.
REQ-014 SHALL have port busy  output  1  high while in any non-IDLE state.
REQ-015 SHALL have port pkt_count  output  16  count of completed packets.

Function
REQ-016 SHALL implement the FSM states IDLE, HDR and XFER; HDR exists only when the macro in REQ-029 is defined.
REQ-017 IDLE: when any s_axis_valid is high, SHALL register a winner by round-robin, searching from (last_grant+1) mod NUM_SRC upward with wrap; next state is HDR (macro on) or XFER (macro off).
REQ-018 Arbitration latency SHALL be exactly one cycle: valid sampled in IDLE at cycle N gives the first m_axis_valid at cycle N+1.
REQ-019 XFER: m_axis_data, m_axis_valid and m_axis_last SHALL combinationally follow the granted source.
- s_axis_ready[grant_id] SHALL equal m_axis_ready.
- All other s_axis_ready bits SHALL be 0.
REQ-020 Outside XFER, all s_axis_ready bits SHALL be 0; m_axis_valid SHALL be 0 in IDLE.
REQ-021 Grant SHALL be held until a handshake with m_axis_last=1 (m_axis_valid and m_axis_ready both high); the FSM then returns to IDLE.
- Minimum one IDLE cycle between packets.
REQ-022 On a last handshake, last_grant SHALL update to grant_id and pkt_count SHALL increment by 1, wrapping 0xFFFF -> 0x0000.
REQ-023 If the granted source drops valid mid-packet, the FSM SHALL stay in XFER with no timeout, and m_axis_valid follows the source low.
REQ-024 A source's valid rising during another source's packet SHALL NOT interrupt that packet.
REQ-025 A single-beat packet (valid and last together on the first beat) SHALL complete in one XFER handshake cycle.

Reset
REQ-026 While rst=0, the block SHALL asynchronously clear:
- state to IDLE, grant_id to 0, last_grant to NUM_SRC-1 (so source 0 has first priority), pkt_count to 0.
- busy, m_axis_valid, m_axis_last and every s_axis_ready bit to 0; m_axis_data to 0.
REQ-027 Reset asserted mid-packet SHALL abandon the packet with no completion count; after release, arbitration restarts from REQ-026 values.
REQ-028 Reset deassertion SHALL take effect on the next rising clk edge with rst=1.

Configuration
REQ-029 Macro UART_ARB_HDR_EN, when defined, SHALL insert one header beat before each packet in state HDR.
- Header data = 0xA0 + grant_id, zero-extended to WIDTH; m_axis_valid=1 and m_axis_last=0.
- All s_axis_ready bits SHALL be 0 during HDR.
- HDR advances to XFER on the m_axis_ready handshake.
- Requires WIDTH >= 8.
REQ-030 When UART_ARB_HDR_EN is undefined, the block SHALL have no HDR state or logic, and IDLE goes directly to XFER.

Verification
REQ-031 Single source: source 2 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), sink ready held high, macro off -> m_axis emits 11,22,33 with last on 33 on consecutive cycles; grant_id=2; pkt_count=1.
REQ-032 Round-robin: all 4 sources request single-beat packets continuously from reset -> grant order 0,1,2,3,0; pkt_count=5 after the fifth last.
REQ-033 Backpressure: m_axis_ready toggles 1,0,1,0 during a 2-byte packet 0xAA,0x55 from source 1 -> each byte is transferred exactly once; s_axis_ready[1] mirrors m_axis_ready; other ready bits stay 0.
REQ-034 No preemption: source 0 mid-packet (4 bytes) while source 3 asserts valid -> all 4 source-0 bytes complete first; source 3 is granted after one IDLE cycle.
REQ-035 Reset mid-packet: rst=0 after byte 2 of 5 -> m_axis_valid=0 and busy=0 immediately (asynchronously); pkt_count=0; first grant after release goes to the lowest-index requester.
REQ-036 Header build with UART_ARB_HDR_EN defined: source 3 sends 0x41 with last -> sink sees 0xA3 (last=0) then 0x41 (last=1); s_axis_ready[3]=0 during the header cycle.
